// File: rtl/flash_seq_pkg.sv
// Shared constants for the SPI NOR flash command sequencer.
// Holds the opcodes, the FSM state codes, the frame byte indices and the per-byte frame builder.
package flash_seq_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WREN = 3'd1;
  localparam state_t ST_GAP  = 3'd2;
  localparam state_t ST_CMD  = 3'd3;
  localparam state_t ST_ADDR = 3'd4;
  localparam state_t ST_DATA = 3'd5;
  localparam state_t ST_POLL = 3'd6;
  localparam state_t ST_DONE = 3'd7;

  // Byte positions within a frame: opcode at 0, address at 1..3, data at 4..7.
  localparam logic [2:0] DATA_FIRST_IDX = 3'd4;
  localparam logic [2:0] DATA_LAST_IDX  = 3'd7;
  localparam logic [2:0] POLL_LAST_IDX  = 3'd1;

  // Byte to shift out for a given frame state and byte index.
  function automatic logic [7:0] frame_byte(input state_t st, input logic [2:0] idx,
                                            input logic wr, input logic [23:0] addr,
                                            input logic [31:0] wdata);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      ST_WREN: b = OP_WREN;
      ST_POLL: b = (idx == 3'd0) ? OP_RDSR : 8'h00;
      ST_CMD:  b = wr ? OP_PP : OP_READ;
      ST_ADDR: begin
        case (idx)
          3'd1:    b = addr[23:16];
          3'd2:    b = addr[15:8];
          default: b = addr[7:0];
        endcase
      end
      ST_DATA: begin
        if (wr) begin
          case (idx)
            3'd4:    b = wdata[31:24];
            3'd5:    b = wdata[23:16];
            3'd6:    b = wdata[15:8];
            default: b = wdata[7:0];
          endcase
        end else begin
          b = 8'h00;
        end
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flash_cmd_sequencer_if.sv
// Request/response, SPI byte-engine and chip-select signals of the flash command sequencer.
interface flash_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        s_css;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, tx_ready, rx_valid, rx_byte,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_byte, s_css
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, tx_ready, rx_valid, rx_byte,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_byte, s_css
  );
endinterface

// File: rtl/flash_cmd_sequencer.sv
// Turns word read/write requests into SPI NOR command frames (READ, WREN+PP+RDSR polling)
// issued one byte at a time to an external byte engine.
module flash_cmd_sequencer
  import flash_seq_pkg::*;
#(
  parameter int CS_GAP     = 2,
  parameter int POLL_LIMIT = 1024
) (
  input logic                  p_clk,
  input logic                  p_resetn,
  flash_cmd_sequencer_if.slave bus
);

  localparam int GAP_W  = $clog2(CS_GAP + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);

  state_t              state_r, gap_next_r, byte_state_s;
  logic [2:0]          byte_idx_r, idx_inc_s;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [POLL_W-1:0]   poll_cnt_r, poll_inc_s;
  logic                in_flight_r, tx_valid_r, s_css_r, req_ready_r;
  logic                rsp_valid_r, rsp_err_r, wr_r, last_byte_s;
  logic [7:0]          tx_byte_r;
  logic [23:0]         addr_r;
  logic [31:0]         wdata_r, rsp_rdata_r;

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.tx_valid  = tx_valid_r;
  assign bus.tx_byte   = tx_byte_r;
  assign bus.s_css     = s_css_r;

  // Frame position bookkeeping: which state the following byte belongs to and whether this is the last.
  always_comb begin
    idx_inc_s    = byte_idx_r + 3'd1;
    poll_inc_s   = poll_cnt_r + POLL_W'(1);
    byte_state_s = state_r;
    last_byte_s  = 1'b0;
    case (state_r)
      ST_WREN: last_byte_s = 1'b1;
      ST_CMD:  byte_state_s = ST_ADDR;
      ST_ADDR: begin
        if (idx_inc_s == DATA_FIRST_IDX) begin
          byte_state_s = ST_DATA;
        end else begin
          byte_state_s = ST_ADDR;
        end
      end
      ST_DATA: last_byte_s = (byte_idx_r == DATA_LAST_IDX);
      ST_POLL: last_byte_s = (byte_idx_r == POLL_LAST_IDX);
      default: last_byte_s = 1'b0;
    endcase
  end

  // Sequencer FSM with inline byte, gap and poll counters.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_r     <= ST_IDLE;
      gap_next_r  <= ST_IDLE;
      byte_idx_r  <= 3'd0;
      gap_cnt_r   <= '0;
      poll_cnt_r  <= '0;
      in_flight_r <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_byte_r   <= 8'h00;
      s_css_r     <= 1'b1;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      wr_r        <= 1'b0;
      addr_r      <= 24'h00_0000;
      wdata_r     <= 32'h0000_0000;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_ready_r && bus.req_valid) begin
            req_ready_r <= 1'b0;
            wr_r        <= bus.req_write;
            addr_r      <= bus.req_addr;
            wdata_r     <= bus.req_wdata;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            byte_idx_r  <= 3'd0;
            poll_cnt_r  <= '0;
            // DONE plus this cycle already give two deselected cycles; pad only for longer gaps.
            if (CS_GAP > 2) begin
              state_r    <= ST_GAP;
              gap_cnt_r  <= GAP_W'(2);
              gap_next_r <= bus.req_write ? ST_WREN : ST_CMD;
            end else begin
              state_r <= bus.req_write ? ST_WREN : ST_CMD;
              s_css_r <= 1'b0;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_W'(CS_GAP - 1)) begin
            state_r    <= gap_next_r;
            s_css_r    <= 1'b0;
            gap_cnt_r  <= '0;
            byte_idx_r <= 3'd0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          rsp_err_r   <= 1'b0;
        end
        default: begin
          if (tx_valid_r) begin
            if (bus.tx_ready) begin
              tx_valid_r  <= 1'b0;
              in_flight_r <= 1'b1;
            end
          end else if (in_flight_r) begin
            if (bus.rx_valid) begin
              in_flight_r <= 1'b0;
              if (state_r == ST_DATA && !wr_r) begin
                rsp_rdata_r <= {rsp_rdata_r[23:0], bus.rx_byte};
              end
              if (last_byte_s) begin
                s_css_r    <= 1'b1;
                byte_idx_r <= 3'd0;
                gap_cnt_r  <= '0;
                case (state_r)
                  ST_WREN: begin
                    state_r    <= ST_GAP;
                    gap_next_r <= ST_CMD;
                  end
                  ST_DATA: begin
                    if (wr_r) begin
                      state_r    <= ST_GAP;
                      gap_next_r <= ST_POLL;
                      poll_cnt_r <= '0;
                    end else begin
                      state_r     <= ST_DONE;
                      rsp_valid_r <= 1'b1;
                    end
                  end
                  ST_POLL: begin
                    poll_cnt_r <= poll_inc_s;
                    // WIP clear wins over the limit on the final allowed poll.
                    if (!bus.rx_byte[0]) begin
                      state_r     <= ST_DONE;
                      rsp_valid_r <= 1'b1;
                    end else if (poll_inc_s == POLL_W'(POLL_LIMIT)) begin
                      state_r     <= ST_DONE;
                      rsp_valid_r <= 1'b1;
                      rsp_err_r   <= 1'b1;
                    end else begin
                      state_r    <= ST_GAP;
                      gap_next_r <= ST_POLL;
                    end
                  end
                  default: state_r <= ST_IDLE;
                endcase
              end else begin
                byte_idx_r <= idx_inc_s;
                state_r    <= byte_state_s;
                tx_valid_r <= 1'b1;
                tx_byte_r  <= frame_byte(byte_state_s, idx_inc_s, wr_r, addr_r, wdata_r);
              end
            end
          end else begin
            tx_valid_r <= 1'b1;
            tx_byte_r  <= frame_byte(state_r, byte_idx_r, wr_r, addr_r, wdata_r);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer with a behavioural SPI byte engine and flash status model.
module tb_flash_cmd_sequencer;

  logic p_clk = 1'b0;
  logic p_resetn = 1'b0;
  always #5 p_clk = ~p_clk;

  flash_cmd_sequencer_if bus ();

  flash_cmd_sequencer #(.CS_GAP(2), .POLL_LIMIT(4)) dut (
    .p_clk   (p_clk),
    .p_resetn(p_resetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Byte engine / flash model state
  logic [7:0]  tx_log[$];
  int          frm_idx = 0;
  logic [7:0]  frm_op = 8'h00;
  logic        pend = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  logic [31:0] rd_data = 32'hDEAD_BEEF;
  int          wip_left = 0;
  bit          wip_stuck = 1'b0;
  bit          stall_en = 1'b0;
  int          stall_cnt = 0;
  bit          inj_idle = 1'b0;

  // Monitor state
  int          rsp_cnt = 0;
  int          overlap_cnt = 0;
  int          gap_min = 1000;
  int          hi_run = 0;
  bit          seen_low = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  // Byte engine: accepts one byte, answers with rx_valid the following cycle.
  initial begin
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    forever begin
      @(posedge p_clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
      if (!p_resetn) pend = 1'b0;
      if (pend) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte  = pend_byte;
        pend = 1'b0;
      end else if (inj_idle) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'hFF;
        inj_idle = 1'b0;
      end
      if (bus.s_css) frm_idx = 0;
      bus.tx_ready = 1'b1;
      if (stall_en && bus.tx_valid && frm_idx == 2 && stall_cnt < 10) begin
        bus.tx_ready = 1'b0;
        stall_cnt++;
        check_val("stall_tx_byte", 64'(bus.tx_byte), 64'h34);
        check_val("stall_css_low", 64'(bus.s_css), 64'h0);
        if (stall_cnt == 5) begin
          bus.rx_valid = 1'b1;
          bus.rx_byte  = 8'hFF;
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tx_log.push_back(bus.tx_byte);
        if (frm_idx == 0) frm_op = bus.tx_byte;
        pend_byte = 8'h00;
        if (frm_op == 8'h03 && frm_idx >= 4) begin
          pend_byte = rd_data[8*(7-frm_idx) +: 8];
        end else if (frm_op == 8'h05 && frm_idx == 1) begin
          if (wip_stuck || wip_left > 0) begin
            pend_byte = 8'h01;
            if (!wip_stuck) wip_left--;
          end
        end
        pend = 1'b1;
        frm_idx++;
      end
    end
  end

  // Response and chip-select monitor.
  initial begin
    forever begin
      @(posedge p_clk); #1;
      if (bus.rsp_valid) begin
        rsp_cnt++;
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
        if (bus.req_ready) overlap_cnt++;
      end
      if (bus.s_css) begin
        hi_run++;
      end else begin
        if (seen_low && hi_run > 0 && hi_run < gap_min) gap_min = hi_run;
        seen_low = 1'b1;
        hi_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge p_clk); #1;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check_val("req_ready_timeout", 64'h0, 64'h1);
  endtask

  task automatic issue(input logic wr, input logic [23:0] a, input logic [31:0] d);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // lat counts cycles from the accepting cycle through the rsp_valid cycle, inclusive.
  task automatic run_req(input logic wr, input logic [23:0] a, input logic [31:0] d, output int lat);
    bit got;
    issue(wr, a, d);
    lat = 2;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    if (!got) check_val("rsp_timeout", 64'h0, 64'h1);
    tick();
    tick();
  endtask

  function automatic logic [63:0] log8();
    logic [63:0] v;
    v = 64'h0;
    for (int i = 0; i < 8 && i < tx_log.size(); i++) v = {v[55:0], tx_log[i]};
    return v;
  endfunction

  function automatic int count05();
    int n;
    n = 0;
    foreach (tx_log[i]) if (tx_log[i] == 8'h05) n++;
    return n;
  endfunction

  logic [7:0] exp_w [17];
  int lat;
  int rc0;
  int acc;

  initial begin
    exp_w = '{8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
              8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 24'h0;
    bus.req_wdata = 32'h0;

    // Reset state
    tick(); tick();
    check_val("rst_css", 64'(bus.s_css), 64'h1);
    check_val("rst_tx_valid", 64'(bus.tx_valid), 64'h0);
    check_val("rst_tx_byte", 64'(bus.tx_byte), 64'h0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check_val("rst_rsp_err", 64'(bus.rsp_err), 64'h0);
    check_val("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'h0);
    p_resetn = 1'b1;
    tick();
    check_val("ready_after_rst", 64'(bus.req_ready), 64'h1);

    // Stray rx_valid while idle is ignored
    inj_idle = 1'b1;
    tick(); tick(); tick();
    check_val("idle_stray_tx_valid", 64'(bus.tx_valid), 64'h0);
    check_val("idle_stray_css", 64'(bus.s_css), 64'h1);
    check_val("idle_stray_ready", 64'(bus.req_ready), 64'h1);

    // Read 0x123456: 2 cycles per byte from this engine -> 8*2 + 2 + 1
    tx_log.delete();
    rc0 = rsp_cnt;
    run_req(1'b0, 24'h123456, 32'h0, lat);
    check_val("rd_ntx", 64'(tx_log.size()), 64'd8);
    check_val("rd_bytes", log8(), 64'h03123456_00000000);
    check_val("rd_rdata", 64'(last_rdata), 64'hDEADBEEF);
    check_val("rd_err", 64'(last_err), 64'h0);
    check_val("rd_latency", 64'(lat), 64'd19);
    check_val("rd_nrsp", 64'(rsp_cnt - rc0), 64'd1);

    // Write with WIP high for 3 polls
    tx_log.delete();
    wip_left = 3;
    gap_min = 1000;
    seen_low = 1'b0;
    rc0 = rsp_cnt;
    run_req(1'b1, 24'h000100, 32'hCAFEF00D, lat);
    check_val("wr_ntx", 64'(tx_log.size()), 64'd17);
    for (int i = 0; i < 17 && i < tx_log.size(); i++) check_val($sformatf("wr_byte%0d", i), 64'(tx_log[i]), 64'(exp_w[i]));
    check_val("wr_npoll", 64'(count05()), 64'd4);
    check_val("wr_rdata", 64'(last_rdata), 64'h0);
    check_val("wr_err", 64'(last_err), 64'h0);
    check_val("wr_gap", 64'(gap_min), 64'd2);
    check_val("wr_nrsp", 64'(rsp_cnt - rc0), 64'd1);

    // Poll timeout: WIP stuck high
    tx_log.delete();
    wip_stuck = 1'b1;
    rc0 = rsp_cnt;
    run_req(1'b1, 24'h000200, 32'h11223344, lat);
    wip_stuck = 1'b0;
    check_val("to_npoll", 64'(count05()), 64'd4);
    check_val("to_ntx", 64'(tx_log.size()), 64'd17);
    check_val("to_err", 64'(last_err), 64'h1);
    check_val("to_nrsp", 64'(rsp_cnt - rc0), 64'd1);

    // tx_ready held low 10 cycles on the second address byte, with a stray rx_valid inside
    tx_log.delete();
    stall_en = 1'b1;
    stall_cnt = 0;
    run_req(1'b0, 24'h123456, 32'h0, lat);
    stall_en = 1'b0;
    check_val("stall_cycles", 64'(stall_cnt), 64'd10);
    check_val("stall_bytes", log8(), 64'h03123456_00000000);
    check_val("stall_ntx", 64'(tx_log.size()), 64'd8);
    check_val("stall_rdata", 64'(last_rdata), 64'hDEADBEEF);

    // Reset during the DATA bytes of a write
    tx_log.delete();
    rc0 = rsp_cnt;
    issue(1'b1, 24'h000300, 32'h55667788);
    for (int i = 0; i < 100 && tx_log.size() < 6; i++) tick();
    check_val("mid_reached_data", 64'(tx_log.size() >= 6), 64'h1);
    p_resetn = 1'b0;
    #1;
    check_val("mid_rst_css", 64'(bus.s_css), 64'h1);
    check_val("mid_rst_tx_valid", 64'(bus.tx_valid), 64'h0);
    tick(); tick();
    p_resetn = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check_val("mid_rst_nrsp", 64'(rsp_cnt - rc0), 64'd0);
    tx_log.delete();
    run_req(1'b0, 24'h123456, 32'h0, lat);
    check_val("post_rst_bytes", log8(), 64'h03123456_00000000);
    check_val("post_rst_rdata", 64'(last_rdata), 64'hDEADBEEF);

    // Back-to-back reads with req_valid held high
    tx_log.delete();
    rc0 = rsp_cnt;
    overlap_cnt = 0;
    gap_min = 1000;
    seen_low = 1'b0;
    acc = 0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 24'h123456;
    for (int i = 0; i < 200 && acc < 2; i++) begin
      if (bus.req_valid && bus.req_ready) acc++;
      tick();
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 200 && (rsp_cnt - rc0) < 2; i++) tick();
    tick(); tick();
    check_val("b2b_accepts", 64'(acc), 64'd2);
    check_val("b2b_nrsp", 64'(rsp_cnt - rc0), 64'd2);
    check_val("b2b_gap", 64'(gap_min), 64'd2);
    check_val("b2b_overlap", 64'(overlap_cnt), 64'd0);
    check_val("b2b_ntx", 64'(tx_log.size()), 64'd16);
    check_val("b2b_rdata", 64'(last_rdata), 64'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/flash_cmd_sequencer.md
FLASH_CMD_SEQUENCER -- requirements
Module: flash_cmd_sequencer

Interface
REQ-001 Parameter CS_GAP, default 2, minimum s_css-high cycles between SPI frames.
REQ-002 Parameter POLL_LIMIT, default 1024, maximum RDSR polls before a write reports timeout.
REQ-003 p_clk  in  1  sole clock; all logic on rising edge.
REQ-004 p_resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid / req_ready  in / out  1 / 1  request handshake.
REQ-006 req_write  in  1  1 = page-program word, 0 = read word.
REQ-007 req_addr  in  24  flash byte address.
REQ-008 req_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-011 rsp_err  out  1  poll timeout flag, valid with rsp_valid.
REQ-012 tx_valid / tx_ready  out / in  1 / 1  byte handshake to SPI byte engine.
REQ-013 tx_byte  out  8  byte to shift out on s_mosi.
REQ-014 rx_valid  in  1  one-cycle pulse: byte engine finished the accepted byte.
REQ-015 rx_byte  in  8  byte sampled from s_miso, valid with rx_valid.
REQ-016 s_css  out  1  flash chip select, active-low.

Function
REQ-017 States: IDLE, WREN, GAP, CMD, ADDR, DATA, POLL, DONE.
REQ-018 req_ready SHALL be 1 only in IDLE; request captured on req_valid&req_ready.
REQ-019 Exactly one byte in flight: after a tx handshake, tx_valid stays 0 until rx_valid is seen.
REQ-020 tx_valid, once asserted, SHALL hold with tx_byte stable until tx_ready.
REQ-021 Read frame: CMD 0x03, ADDR [23:16],[15:8],[7:0], DATA 4 dummy 0x00 bytes; rx_bytes fill rsp_rdata [31:24] first.
REQ-022 Write sequence: frame 0x06 (WREN), GAP, frame 0x02 + 3 addr bytes + req_wdata [31:24]..[7:0], GAP, then POLL.
REQ-023 POLL frame: 0x05 then one 0x00 byte; frame ends; if rx_byte[0] (WIP) = 1, GAP and repeat, else DONE.
REQ-024 Poll counter increments per POLL frame; reaching POLL_LIMIT with WIP still 1 -> DONE with rsp_err=1.
REQ-025 s_css SHALL go low one cycle before the first tx_valid of a frame and high the cycle after the last rx_valid.
REQ-026 GAP holds s_css high exactly CS_GAP cycles (counter 0..CS_GAP-1), then continues.
REQ-027 DONE: rsp_valid=1 for one cycle, rsp_err=0 unless timeout, rsp_rdata=0 for writes; next cycle IDLE.
REQ-028 Read latency from acceptance to rsp_valid = 8 byte transfers + 2 cycles of CS overhead + 1.
REQ-029 rx_valid arriving with no byte in flight SHALL be ignored.
REQ-030 A new request SHALL never be accepted in the same cycle rsp_valid is high.

Reset
REQ-031 On p_resetn=0, asynchronously: state IDLE, s_css=1, tx_valid=0, tx_byte=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0, counters=0.
REQ-032 req_ready SHALL rise the first cycle after p_resetn deasserts.
REQ-033 Reset mid-transaction drops the transaction with no response; s_css high immediately.

Structure
REQ-034 Package flash_seq_pkg holds opcodes (0x03, 0x02, 0x06, 0x05), state enum, and byte-count constants.
REQ-035 No sub-module; byte, gap and poll counters inline in flash_cmd_sequencer.

Verification
REQ-036 Read addr 0x123456, byte model returns 0xDE,0xAD,0xBE,0xEF in DATA -> tx 03 12 34 56 00 00 00 00, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Write addr 0x000100 data 0xCAFEF00D, WIP=1 for 3 polls then 0 -> frames 06 | 02 00 01 00 CA FE F0 0D | 4x(05 00), rsp_err=0.
REQ-038 POLL_LIMIT=4, WIP stuck 1 -> exactly 4 poll frames, rsp_valid with rsp_err=1.
REQ-039 tx_ready held low 10 cycles mid-ADDR -> tx_byte stable, s_css stays low, no byte skipped.
REQ-040 p_resetn pulsed low during DATA of a write -> s_css=1 and tx_valid=0 same cycle, no rsp_valid, next read completes normally.
REQ-041 Back-to-back reads with req_valid held high -> each frame separated by >= CS_GAP high cycles, two rsp_valid pulses.
